// File: rtl/addsat_sched.sv
// addsat_sched: time-shares one external 16-bit saturating adder between two requesters
// with round-robin arbitration. Narrow ops take one adder pass, wide (32-bit) ops take a
// low pass then a high pass with the carry chained between them.
// Latency from the sampling edge: grant +1, narrow done +2, wide done +3.
// Backpressure: requests are sampled only in IDLE; a requester holds reqN until its grant.
// Ports:
//   clk, reset                      clock, async active-high reset
//   reqN, aN, bN, cinN, satN,
//   eightbitN, hicinhN, wideN       request and operands from requester N (N = 0, 1)
//   grantN, doneN, rN, coN          capture pulse, result-valid pulse, held result/carry
//   add_a, add_b, add_cin, add_sat,
//   add_eightbit, add_hicinh        drive to the shared adder (all 0 while idle)
//   add_r, add_co                   combinational result back from the shared adder
module addsat_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        cin0,
  input  logic        sat0,
  input  logic        eightbit0,
  input  logic        hicinh0,
  input  logic        wide0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic        cin1,
  input  logic        sat1,
  input  logic        eightbit1,
  input  logic        hicinh1,
  input  logic        wide1,
  output logic        grant0,
  output logic        grant1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] r0,
  output logic [31:0] r1,
  output logic        co0,
  output logic        co1,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  output logic        add_sat,
  output logic        add_eightbit,
  output logic        add_hicinh,
  input  logic [15:0] add_r,
  input  logic        add_co
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_rr;          // id of the last requester served
  logic        r_id;
  logic [31:0] r_a, r_b;
  logic        r_cin, r_sat, r_eb, r_hci, r_wide;
  logic [15:0] r_res_lo;
  logic        r_cy;
  logic [1:0]  r_grant, r_done;
  logic [31:0] r_res0, r_res1;
  logic        r_co0, r_co1;

  logic        w_any, w_win, w_fin;
  logic [31:0] w_res;

  // On a tie the requester that was not served last wins.
  assign w_any = req0 | req1;
  assign w_win = (req0 & req1) ? ~r_rr : req1;

  // High pass carries the low half captured in the previous cycle.
  assign w_res = (r_state == HI) ? {add_r, r_res_lo} : {16'h0, add_r};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fin        = 1'b0;
    add_a        = 16'h0;
    add_b        = 16'h0;
    add_cin      = 1'b0;
    add_sat      = 1'b0;
    add_eightbit = 1'b0;
    add_hicinh   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = LO;
      end
      LO: begin
        add_a   = r_a[15:0];
        add_b   = r_b[15:0];
        add_cin = r_cin;
        // Lane controls would corrupt the low half of a 32-bit add.
        if (!r_wide) begin
          add_sat      = r_sat;
          add_eightbit = r_eb;
          add_hicinh   = r_hci;
          w_state_nxt  = IDLE;
          w_fin        = 1'b1;
        end else begin
          w_state_nxt  = HI;
        end
      end
      HI: begin
        add_a       = r_a[31:16];
        add_b       = r_b[31:16];
        add_cin     = r_cy;
        w_state_nxt = IDLE;
        w_fin       = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr     <= 1'b1;
      r_id     <= 1'b0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_cin    <= 1'b0;
      r_sat    <= 1'b0;
      r_eb     <= 1'b0;
      r_hci    <= 1'b0;
      r_wide   <= 1'b0;
      r_res_lo <= 16'h0;
      r_cy     <= 1'b0;
      r_grant  <= 2'b00;
      r_done   <= 2'b00;
      r_res0   <= 32'h0;
      r_res1   <= 32'h0;
      r_co0    <= 1'b0;
      r_co1    <= 1'b0;
    end else begin
      r_grant <= 2'b00;
      r_done  <= 2'b00;
      if (r_state == IDLE && w_any) begin
        r_id           <= w_win;
        r_rr           <= w_win;
        r_a            <= w_win ? a1 : a0;
        r_b            <= w_win ? b1 : b0;
        r_cin          <= w_win ? cin1 : cin0;
        r_sat          <= w_win ? sat1 : sat0;
        r_eb           <= w_win ? eightbit1 : eightbit0;
        r_hci          <= w_win ? hicinh1 : hicinh0;
        r_wide         <= w_win ? wide1 : wide0;
        r_grant[w_win] <= 1'b1;
      end
      if (r_state == LO) begin
        r_res_lo <= add_r;
        r_cy     <= add_co;
      end
      if (w_fin) begin
        r_done[r_id] <= 1'b1;
        if (r_id) begin
          r_res1 <= w_res;
          r_co1  <= add_co;
        end else begin
          r_res0 <= w_res;
          r_co0  <= add_co;
        end
      end
    end
  end

  assign grant0 = r_grant[0];
  assign grant1 = r_grant[1];
  assign done0  = r_done[0];
  assign done1  = r_done[1];
  assign r0     = r_res0;
  assign r1     = r_res1;
  assign co0    = r_co0;
  assign co1    = r_co1;

endmodule

// File: tb/tb_addsat_sched.sv
// tb_addsat_sched: drives addsat_sched with directed and random ops, models the shared
// saturating adder, and checks grant/done timing, results and arbitration order.
module tb_addsat_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req[2];
  logic [31:0] a[2], b[2];
  logic        cin[2], sat[2], eb[2], hci[2], wide[2];
  logic        gnt[2], dn[2];
  logic [31:0] ro[2];
  logic        coo[2];
  logic [15:0] add_a, add_b, add_r;
  logic        add_cin, add_sat, add_eightbit, add_hicinh, add_co;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_r[2];
  logic        exp_co[2];
  int          last_id;

  // Adder model: b acts as a signed delta when saturating; lanes are independent in 8-bit mode.
  function automatic logic [8:0] lane_sat(logic [8:0] s, logic bs, logic en);
    if (en && s[8] && !bs) return 9'h1FF;
    if (en && !s[8] && bs) return 9'h000;
    return s;
  endfunction

  function automatic logic [16:0] adder_fn(logic [15:0] x, logic [15:0] y,
                                           logic c, logic s, logic e, logic h);
    logic [8:0]  l, u;
    logic [12:0] lo12;
    logic [4:0]  hi4;
    logic [16:0] t;
    if (e) begin
      l = {1'b0, x[7:0]} + {1'b0, y[7:0]} + 9'(c);
      u = {1'b0, x[15:8]} + {1'b0, y[15:8]};
      l = lane_sat(l, y[7], s);
      u = lane_sat(u, y[15], s);
      return {u[8], u[7:0], l[7:0]};
    end
    if (h) begin
      lo12 = {1'b0, x[11:0]} + {1'b0, y[11:0]} + 13'(c);
      hi4  = {1'b0, x[15:12]} + {1'b0, y[15:12]};
      t    = {hi4, lo12[11:0]};
    end else begin
      t = {1'b0, x} + {1'b0, y} + 17'(c);
    end
    if (s && t[16] && !y[15])      t[15:0] = 16'hFFFF;
    else if (s && !t[16] && y[15]) t[15:0] = 16'h0000;
    return t;
  endfunction

  assign {add_co, add_r} = adder_fn(add_a, add_b, add_cin, add_sat, add_eightbit, add_hicinh);

  addsat_sched dut (
    .clk(clk), .reset(reset),
    .req0(req[0]), .a0(a[0]), .b0(b[0]), .cin0(cin[0]), .sat0(sat[0]),
    .eightbit0(eb[0]), .hicinh0(hci[0]), .wide0(wide[0]),
    .req1(req[1]), .a1(a[1]), .b1(b[1]), .cin1(cin[1]), .sat1(sat[1]),
    .eightbit1(eb[1]), .hicinh1(hci[1]), .wide1(wide[1]),
    .grant0(gnt[0]), .grant1(gnt[1]), .done0(dn[0]), .done1(dn[1]),
    .r0(ro[0]), .r1(ro[1]), .co0(coo[0]), .co1(coo[1]),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sat(add_sat),
    .add_eightbit(add_eightbit), .add_hicinh(add_hicinh),
    .add_r(add_r), .add_co(add_co)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one op on an idle scheduler and follows it to its done pulse.
  task automatic run_op(int id, logic [31:0] xa, logic [31:0] xb, logic xc,
                        logic xs, logic xe, logic xh, logic xw);
    int          o;
    int          k;
    logic [32:0] w;
    logic [16:0] n;
    logic [16:0] lo;
    logic [31:0] er;
    logic        ec;
    o = 1 - id;
    if (xw) begin
      w  = {1'b0, xa} + {1'b0, xb} + 33'(xc);
      er = w[31:0];
      ec = w[32];
    end else begin
      n  = adder_fn(xa[15:0], xb[15:0], xc, xs, xe, xh);
      er = {16'h0, n[15:0]};
      ec = n[16];
    end
    lo = {1'b0, xa[15:0]} + {1'b0, xb[15:0]} + 17'(xc);
    req[id] = 1'b1; a[id] = xa; b[id] = xb; cin[id] = xc;
    sat[id] = xs; eb[id] = xe; hci[id] = xh; wide[id] = xw;
    tick;
    total++;
    if (gnt[id] !== 1'b1 || gnt[o] !== 1'b0) begin
      bad++;
      $display("FAIL grant id=%0d: grant0=%b grant1=%b, want only grant%0d", id, gnt[0], gnt[1], id);
    end
    // Operands were captured; scramble them to expose late sampling.
    req[id] = 1'b0; a[id] = $urandom; b[id] = $urandom; cin[id] = 1'($urandom);
    sat[id] = 1'($urandom); eb[id] = 1'($urandom); hci[id] = 1'($urandom); wide[id] = 1'($urandom);
    total++;
    if (add_a !== xa[15:0] || add_b !== xb[15:0] || add_cin !== xc ||
        add_sat !== (xs & ~xw) || add_eightbit !== (xe & ~xw) || add_hicinh !== (xh & ~xw)) begin
      bad++;
      $display("FAIL lo_pass id=%0d: a=%h b=%h cin=%b ctl=%b%b%b, want a=%h b=%h cin=%b ctl=%b%b%b",
               id, add_a, add_b, add_cin, add_sat, add_eightbit, add_hicinh,
               xa[15:0], xb[15:0], xc, xs & ~xw, xe & ~xw, xh & ~xw);
    end
    k = 1;
    while (k < 6 && dn[0] !== 1'b1 && dn[1] !== 1'b1) begin
      tick;
      k++;
      if (xw && k == 2) begin
        total++;
        if (add_a !== xa[31:16] || add_b !== xb[31:16] || add_cin !== lo[16] ||
            add_sat !== 1'b0 || add_eightbit !== 1'b0 || add_hicinh !== 1'b0) begin
          bad++;
          $display("FAIL hi_pass id=%0d: a=%h b=%h cin=%b, want a=%h b=%h cin=%b ctl=000",
                   id, add_a, add_b, add_cin, xa[31:16], xb[31:16], lo[16]);
        end
      end
    end
    total++;
    if (k !== (xw ? 3 : 2)) begin
      bad++;
      $display("FAIL latency id=%0d wide=%b: done at +%0d, want +%0d", id, xw, k, xw ? 3 : 2);
    end
    total++;
    if (dn[id] !== 1'b1 || dn[o] !== 1'b0) begin
      bad++;
      $display("FAIL done id=%0d: done0=%b done1=%b", id, dn[0], dn[1]);
    end
    total++;
    if (ro[id] !== er || coo[id] !== ec) begin
      bad++;
      $display("FAIL result id=%0d a=%h b=%h: r=%h co=%b, want r=%h co=%b", id, xa, xb, ro[id], coo[id], er, ec);
    end
    total++;
    if (ro[o] !== exp_r[o] || coo[o] !== exp_co[o]) begin
      bad++;
      $display("FAIL other_held id=%0d: r=%h co=%b, want r=%h co=%b", o, ro[o], coo[o], exp_r[o], exp_co[o]);
    end
    exp_r[id]  = er;
    exp_co[id] = ec;
    last_id    = id;
  endtask

  task automatic check_all_zero(string tag);
    total++;
    if (gnt[0] !== 1'b0 || gnt[1] !== 1'b0 || dn[0] !== 1'b0 || dn[1] !== 1'b0 ||
        ro[0] !== 32'h0 || ro[1] !== 32'h0 || coo[0] !== 1'b0 || coo[1] !== 1'b0 ||
        add_a !== 16'h0 || add_b !== 16'h0 || add_cin !== 1'b0 || add_sat !== 1'b0 ||
        add_eightbit !== 1'b0 || add_hicinh !== 1'b0) begin
      bad++;
      $display("FAIL %s: g=%b%b d=%b%b r0=%h r1=%h co=%b%b add_a=%h add_b=%h ctl=%b%b%b%b, want all 0",
               tag, gnt[0], gnt[1], dn[0], dn[1], ro[0], ro[1], coo[0], coo[1],
               add_a, add_b, add_cin, add_sat, add_eightbit, add_hicinh);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    check_all_zero("reset_state");
    reset = 1'b0;
    exp_r[0] = 32'h0; exp_r[1] = 32'h0;
    exp_co[0] = 1'b0; exp_co[1] = 1'b0;
    last_id = 1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; a[i] = 32'h0; b[i] = 32'h0; cin[i] = 1'b0;
      sat[i] = 1'b0; eb[i] = 1'b0; hci[i] = 1'b0; wide[i] = 1'b0;
    end
    do_reset;
    tick;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_arbitration;
    logic [31:0] xa[2], xb[2];
    logic        xc[2], xs[2], xe[2], xh[2];
    logic [16:0] n;
    int          exp_next, gcount, dcount;
    for (int i = 0; i < 2; i++) begin
      xa[i] = $urandom; xb[i] = $urandom; xc[i] = 1'($urandom);
      xs[i] = 1'($urandom); xe[i] = 1'($urandom); xh[i] = 1'($urandom);
      req[i] = 1'b1; a[i] = xa[i]; b[i] = xb[i]; cin[i] = xc[i];
      sat[i] = xs[i]; eb[i] = xe[i]; hci[i] = xh[i]; wide[i] = 1'b0;
    end
    exp_next = 1 - last_id;
    gcount = 0;
    dcount = 0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      tick;
      total++;
      if ((gnt[0] === 1'b1 && gnt[1] === 1'b1) || (dn[0] === 1'b1 && dn[1] === 1'b1)) begin
        bad++;
        $display("FAIL arb_exclusive cyc=%0d: grant=%b%b done=%b%b", cyc, gnt[0], gnt[1], dn[0], dn[1]);
      end
      if (gnt[0] === 1'b1 || gnt[1] === 1'b1) begin
        total++;
        if (gnt[exp_next] !== 1'b1) begin
          bad++;
          $display("FAIL arb_order cyc=%0d: grant=%b%b, want grant%0d", cyc, gnt[0], gnt[1], exp_next);
        end
        gcount++;
        exp_next = 1 - exp_next;
      end
      for (int i = 0; i < 2; i++) begin
        if (dn[i] === 1'b1) begin
          dcount++;
          n = adder_fn(xa[i][15:0], xb[i][15:0], xc[i], xs[i], xe[i], xh[i]);
          exp_r[i] = {16'h0, n[15:0]};
          exp_co[i] = n[16];
          last_id = i;
          total++;
          if (ro[i] !== exp_r[i] || coo[i] !== exp_co[i]) begin
            bad++;
            $display("FAIL arb_result id=%0d: r=%h co=%b, want r=%h co=%b", i, ro[i], coo[i], exp_r[i], exp_co[i]);
          end
        end
      end
      if (cyc == 15) begin
        req[0] = 1'b0;
        req[1] = 1'b0;
      end
    end
    total++;
    if (gcount !== 8 || dcount !== 8) begin
      bad++;
      $display("FAIL arb_rate: grants=%0d dones=%0d, want 8 and 8", gcount, dcount);
    end
  endtask

  task automatic test_narrow;
    run_op(0, 32'h0000_1234, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ro[0] !== 32'h0000_1235 || coo[0] !== 1'b0) begin
      bad++;
      $display("FAIL narrow_plain: r0=%h co0=%b, want 00001235 0", ro[0], coo[0]);
    end
    for (int i = 0; i < 6; i++)
      run_op(int'($urandom_range(1)), $urandom, $urandom, 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic test_sat;
    run_op(1, 32'h0000_FFF0, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (ro[1] !== 32'h0000_FFFF || coo[1] !== 1'b1) begin
      bad++;
      $display("FAIL sat_high: r1=%h co1=%b, want 0000ffff 1", ro[1], coo[1]);
    end
    run_op(1, 32'h0000_0010, 32'h0000_FFE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (ro[1] !== 32'h0) begin
      bad++;
      $display("FAIL sat_low: r1=%h, want 00000000", ro[1]);
    end
  endtask

  task automatic test_eightbit;
    run_op(0, 32'h0000_00F0, 32'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (ro[0] !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL eightbit_sat: r0=%h, want 000000ff", ro[0]);
    end
  endtask

  task automatic test_wide;
    run_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (ro[1] !== 32'h0001_0000 || coo[1] !== 1'b0) begin
      bad++;
      $display("FAIL wide_chain: r1=%h co1=%b, want 00010000 0", ro[1], coo[1]);
    end
    run_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (ro[1] !== 32'h0 || coo[1] !== 1'b1) begin
      bad++;
      $display("FAIL wide_wrap: r1=%h co1=%b, want 00000000 1", ro[1], coo[1]);
    end
    // Lane controls set on wide ops must not reach the adder.
    for (int i = 0; i < 6; i++)
      run_op(int'($urandom_range(1)), $urandom, $urandom, 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++)
      run_op(int'($urandom_range(1)), $urandom, $urandom, 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_midop;
    int saw_done;
    run_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    req[1] = 1'b1; a[1] = 32'h0000_FFFF; b[1] = 32'h0000_0001; cin[1] = 1'b0;
    sat[1] = 1'b0; eb[1] = 1'b0; hci[1] = 1'b0; wide[1] = 1'b1;
    tick;
    req[1] = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    check_all_zero("reset_midop");
    tick;
    reset = 1'b0;
    exp_r[0] = 32'h0; exp_r[1] = 32'h0;
    exp_co[0] = 1'b0; exp_co[1] = 1'b0;
    last_id = 1;
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (dn[1] === 1'b1 || gnt[1] === 1'b1) saw_done++;
    end
    total++;
    if (saw_done !== 0 || ro[1] !== 32'h0) begin
      bad++;
      $display("FAIL reset_discard: stray done/grant cycles=%0d r1=%h, want 0 and 00000000", saw_done, ro[1]);
    end
    run_op(0, 32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    test_reset;
    test_arbitration;
    test_narrow;
    test_sat;
    test_eightbit;
    test_wide;
    test_back_to_back;
    test_arbitration;
    test_reset_midop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsat_sched.md
Name: addsat_sched

Overview:
- Time-shares one external 16-bit saturating adder (carry-select fa4cs/cg4 array with sat/eightbit/hicinh controls) between two requesters, e.g. the blitter intensity path and the GPU pixel path.
- Round-robin arbitration; operands captured on grant.
- Two ops: narrow (one 16-bit pass) and wide (32-bit add sequenced as low then high 16-bit passes, carry chained between them).
- Results are registered and returned per requester with a done pulse.

Parameters:
- none (16-bit adder lanes and two requesters are fixed).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- reqN (N=0,1)  in  1  request; sampled only in IDLE.
- aN, bN  in  32  operands; bit 0 = LSB; narrow ops use [15:0].
- cinN  in  1  carry in.
- satN  in  1  saturate enable (narrow only).
- eightbitN  in  1  8-bit lane mode (narrow only).
- hicinhN  in  1  high-nibble carry inhibit (narrow only).
- wideN  in  1  1 = 32-bit op.
- grantN  out  1  one-cycle pulse: operands captured; requester drops reqN this cycle.
- doneN  out  1  one-cycle pulse: rN/coN valid.
- rN  out  32  result; held until that requester's next done.
- coN  out  1  carry out; held with rN.
- add_a, add_b  out  16  adder operands.
- add_cin, add_sat, add_eightbit, add_hicinh  out  1 each  adder controls.
- add_r  in  16  adder result (combinational from add_* outputs).
- add_co  in  1  adder carry out.

Behaviour:
- Reset: state IDLE, rr pointer = 1 (requester 0 wins the first tie). All outputs 0: grantN, doneN, rN, coN, add_* all 0.
- States: IDLE, LO, HI.
- IDLE:
  - add_* driven 0.
  - If any reqN: pick the winner (sole requester, or on a tie the one not equal to rr).
  - At the edge: capture winner's a, b, cin, sat, eightbit, hicinh, wide, and id; set rr = id; assert grant[id] for the next cycle; go to LO.
- LO:
  - add_a/add_b = captured [15:0]; add_cin = captured cin.
  - Narrow: add_sat, add_eightbit, add_hicinh = captured values.
  - Wide: those three forced 0.
  - At the edge: res_lo <= add_r, cy <= add_co.
  - Narrow: go to IDLE; on that edge r[id] <= {16'h0, add_r}, co[id] <= add_co, done[id] <= 1.
  - Wide: go to HI.
- HI:
  - add_a/add_b = captured [31:16]; add_cin = cy; sat/eightbit/hicinh = 0.
  - At the edge: r[id] <= {add_r, res_lo}, co[id] <= add_co, done[id] <= 1; go to IDLE.
- Latency, counted from the edge that samples req:
  - grant in cycle +1.
  - Narrow: done in cycle +2.
  - Wide: done in cycle +3.
- Throughput: one narrow op per 2 cycles, one wide op per 3 cycles.
- A new request is sampled in the IDLE cycle coincident with a done pulse, so back-to-back ops have no bubble beyond IDLE.
- The scheduler does no arithmetic. Saturation, carry and the 8-bit lane split are entirely the adder's; results are passed through unchanged.
- doneN/grantN are never asserted for both requesters in the same cycle.
- rN/coN of the requester that was not served are unchanged.
- reset asserted mid-op: immediate return to IDLE with all outputs 0; the in-flight op is discarded with no done. Requesters must re-request after reset.
- reqN high outside IDLE is ignored; a requester still holding req when IDLE returns is re-served.

Test Plan:
- Narrow plain: req0, a0=0x1234, b0=0x0001, cin0=0, sat0=0 -> grant0 at +1, done0 at +2, r0=0x00001235, co0=0.
- Narrow saturate: req1, a1=0xFFF0, b1=0x0020, sat1=1 -> r1=0x0000FFFF, co1=1. Then a1=0x0010, b1=0xFFE0, sat1=1 -> r1=0x00000000.
- Eight-bit saturate: req0, a0=0x00F0, b0=0x0020, sat0=1, eightbit0=1 -> r0=0x000000FF (no carry into upper byte).
- Wide carry chain: req1, wide1=1, a1=0x0000FFFF, b1=0x00000001 -> done1 at +3, r1=0x00010000, co1=0. Check add_cin=1 during HI. Also a1=0xFFFFFFFF, b1=1 -> r1=0, co1=1.
- Arbitration: req0 and req1 held continuously, narrow ops -> grants alternate 0,1,0,1; done every 2 cycles; no cycle with both grants.
- Reset mid-op: assert reset during HI of a wide op -> next cycle all outputs 0, state IDLE, no done1. A subsequent req0 is served with grant0 at +1.
